filt_frame_packer: RTL and testbench

Downstream consumer of the FIR averaging stage. Takes the 8-bit filtered sample stream and groups it into fixed-length frames. For each frame it computes the sum, the peak and a frame sequence number. Completed frame records are buffered in a small FIFO and drained through a valid/ready handshake toward the monitor/host side.

---
 rtl/filt_pkg.sv | 21 ++
 rtl/filt_frame_fifo.sv | 82 ++++++++
 rtl/filt_frame_packer.sv | 106 ++++++++++
 tb/tb_filt_frame_packer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// Shared definitions for the filter frame path: default widths, sum-width
// derivation and the frame record layout used by the packer and the monitor.
package filt_pkg;

  localparam int FILT_DATA_W    = 8;
  localparam int FILT_FRAME_LEN = 4;
  localparam int FILT_ID_W      = 8;

  function automatic int calc_sum_w(input int data_w, input int frame_len);
    return data_w + $clog2(frame_len);
  endfunction

  localparam int FILT_SUM_W = calc_sum_w(FILT_DATA_W, FILT_FRAME_LEN);

  typedef struct packed {
    logic [FILT_SUM_W-1:0]  sum;
    logic [FILT_DATA_W-1:0] max;
    logic [FILT_ID_W-1:0]   id;
  } frame_rec_t;

endpackage

// File: rtl/filt_frame_fifo.sv
// Show-ahead synchronous FIFO of frame records; the head is held in a register
// so it stays at its last value once the FIFO drains.
module filt_frame_fifo #(
  parameter int REC_W = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [REC_W-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [REC_W-1:0] o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [REC_W-1:0] r_head;
  logic             r_empty;

  logic             w_full;
  logic             w_rd_en;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_rd_ptr_n;
  logic [CNT_W-1:0] w_count_n;
  logic [REC_W-1:0] w_head_n;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_rd_en = i_pop & ~r_empty;
  assign w_wr_en = i_push & (~w_full | w_rd_en);

  // Next read pointer, occupancy and head record (bypassing a write into an empty slot).
  always_comb begin
    w_rd_ptr_n = w_rd_en ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_n = r_count + CNT_W'(1);
      2'b01:   w_count_n = r_count - CNT_W'(1);
      default: w_count_n = r_count;
    endcase
    if (w_count_n == CNT_W'(0)) begin
      w_head_n = r_head;
    end else if (w_wr_en && (r_wr_ptr == w_rd_ptr_n)) begin
      w_head_n = i_data;
    end else begin
      w_head_n = r_mem[w_rd_ptr_n];
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_n;
      r_count  <= w_count_n;
      r_head   <= w_head_n;
      r_empty  <= (w_count_n == CNT_W'(0));
    end
  end

  assign o_full  = w_full;
  assign o_empty = r_empty;
  assign o_head  = r_head;

endmodule

// File: rtl/filt_frame_packer.sv
// Groups filtered samples into fixed-length frames, computes sum/peak/id per
// frame and queues the records for a valid/ready consumer.
module filt_frame_packer
  import filt_pkg::*;
#(
  parameter int DATA_W     = FILT_DATA_W,
  parameter int FRAME_LEN  = FILT_FRAME_LEN,
  parameter int FIFO_DEPTH = 4,
  localparam int SUM_W     = calc_sum_w(DATA_W, FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [SUM_W-1:0]  o_sum,
  output logic [DATA_W-1:0] o_max,
  output logic [7:0]        o_frame_id,
  output logic              o_overflow
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int REC_W = SUM_W + DATA_W + 8;

  logic [CNT_W-1:0]  r_cnt;
  logic [SUM_W-1:0]  r_sum_acc;
  logic [DATA_W-1:0] r_max_acc;
  logic [7:0]        r_frame_id;
  logic              r_overflow;

  logic              w_first;
  logic              w_last;
  logic [SUM_W-1:0]  w_data_ext;
  logic [SUM_W-1:0]  w_sum_next;
  logic [DATA_W-1:0] w_max_next;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [REC_W-1:0]  w_push_rec;
  logic [REC_W-1:0]  w_head;

  assign w_first    = (r_cnt == CNT_W'(0));
  assign w_last     = i_valid & (r_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_data_ext = {{(SUM_W-DATA_W){1'b0}}, i_data};
  assign w_pop      = ~w_empty & o_ready;

  // The first sample of a frame loads the accumulators instead of folding into them.
  always_comb begin
    if (w_first) begin
      w_sum_next = w_data_ext;
      w_max_next = i_data;
    end else begin
      w_sum_next = r_sum_acc + w_data_ext;
      w_max_next = (i_data > r_max_acc) ? i_data : r_max_acc;
    end
  end

  assign w_push_rec = {w_sum_next, w_max_next, r_frame_id};

  // Accumulators, frame counter, frame id and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_sum_acc  <= '0;
      r_max_acc  <= '0;
      r_frame_id <= 8'd0;
      r_overflow <= 1'b0;
    end else begin
      if (i_valid) begin
        r_sum_acc <= w_sum_next;
        r_max_acc <= w_max_next;
        if (w_last) begin
          r_cnt      <= '0;
          r_frame_id <= r_frame_id + 8'd1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (w_last && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  filt_frame_fifo #(
    .REC_W (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_last),
    .i_data  (w_push_rec),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign o_valid    = ~w_empty;
  assign o_sum      = w_head[REC_W-1 -: SUM_W];
  assign o_max      = w_head[8 +: DATA_W];
  assign o_frame_id = w_head[7:0];
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_filt_frame_packer.sv
// Directed self-checking bench for filt_frame_packer at default parameters.
module tb_filt_frame_packer;

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_valid;
  logic       o_ready;
  logic [9:0] o_sum;
  logic [7:0] o_max;
  logic [7:0] o_frame_id;
  logic       o_overflow;

  int total;
  int bad;

  filt_frame_packer dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_sum      (o_sum),
    .o_max      (o_max),
    .o_frame_id (o_frame_id),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic put(input logic v, input logic [7:0] d);
    i_valid = v;
    i_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_data  = 8'd0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic feed_frame(input logic [7:0] d);
    for (int k = 0; k < 4; k++) put(1'b1, d);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'd0;
    o_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sum", 32'(o_sum), 32'd0);
    chk("rst_id", 32'(o_frame_id), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: basic frame, visible for exactly one cycle
    put(1'b1, 8'd10); put(1'b1, 8'd20); put(1'b1, 8'd30);
    chk("t1_not_yet", 32'(o_valid), 32'd0);
    put(1'b1, 8'd40);
    chk("t1_valid", 32'(o_valid), 32'd1);
    chk("t1_sum", 32'(o_sum), 32'd100);
    chk("t1_max", 32'(o_max), 32'd40);
    chk("t1_id", 32'(o_frame_id), 32'd0);
    put(1'b0, 8'd0);
    chk("t1_one_cycle", 32'(o_valid), 32'd0);
    chk("t1_hold_sum", 32'(o_sum), 32'd100);

    // 2: max-value frame, then accumulator restart
    do_reset();
    feed_frame(8'd255);
    chk("t2_sum_max", 32'(o_sum), 32'd1020);
    chk("t2_max_max", 32'(o_max), 32'd255);
    put(1'b1, 8'd0); put(1'b1, 8'd7); put(1'b1, 8'd3); put(1'b1, 8'd1);
    chk("t2_sum", 32'(o_sum), 32'd11);
    chk("t2_max", 32'(o_max), 32'd7);
    chk("t2_id", 32'(o_frame_id), 32'd1);

    // 3: invalid cycles carry junk that must not leak in
    put(1'b1, 8'd5); put(1'b0, 8'd99); put(1'b1, 8'd5); put(1'b0, 8'd99);
    put(1'b1, 8'd5); put(1'b0, 8'd99);
    chk("t3_not_yet", 32'(o_valid), 32'd0);
    put(1'b1, 8'd5);
    chk("t3_valid", 32'(o_valid), 32'd1);
    chk("t3_sum", 32'(o_sum), 32'd20);
    chk("t3_max", 32'(o_max), 32'd5);
    chk("t3_id", 32'(o_frame_id), 32'd2);

    // 4: backpressure, overflow drop, ordered drain, id gap
    do_reset();
    o_ready = 1'b0;
    feed_frame(8'd1);
    chk("t4_first_id", 32'(o_frame_id), 32'd0);
    chk("t4_first_sum", 32'(o_sum), 32'd4);
    feed_frame(8'd2); feed_frame(8'd3); feed_frame(8'd4);
    chk("t4_ovf_before", 32'(o_overflow), 32'd0);
    feed_frame(8'd5);
    chk("t4_ovf", 32'(o_overflow), 32'd1);
    chk("t4_valid_held", 32'(o_valid), 32'd1);
    chk("t4_id_stable", 32'(o_frame_id), 32'd0);
    chk("t4_sum_stable", 32'(o_sum), 32'd4);
    o_ready = 1'b1;
    put(1'b0, 8'd0);
    chk("t4_drain_id1", 32'(o_frame_id), 32'd1);
    chk("t4_drain_sum1", 32'(o_sum), 32'd8);
    put(1'b0, 8'd0);
    chk("t4_drain_id2", 32'(o_frame_id), 32'd2);
    put(1'b0, 8'd0);
    chk("t4_drain_id3", 32'(o_frame_id), 32'd3);
    chk("t4_drain_sum3", 32'(o_sum), 32'd16);
    put(1'b0, 8'd0);
    chk("t4_drained", 32'(o_valid), 32'd0);
    feed_frame(8'd9);
    chk("t4_gap_id", 32'(o_frame_id), 32'd5);
    chk("t4_gap_sum", 32'(o_sum), 32'd36);
    chk("t4_ovf_sticky", 32'(o_overflow), 32'd1);

    // 5: full FIFO with pop on the same edge as a push
    do_reset();
    o_ready = 1'b0;
    feed_frame(8'd1); feed_frame(8'd2); feed_frame(8'd3); feed_frame(8'd4);
    put(1'b1, 8'd5); put(1'b1, 8'd5); put(1'b1, 8'd5);
    o_ready = 1'b1;
    put(1'b1, 8'd5);
    chk("t5_ovf", 32'(o_overflow), 32'd0);
    chk("t5_id1", 32'(o_frame_id), 32'd1);
    put(1'b0, 8'd0);
    chk("t5_id2", 32'(o_frame_id), 32'd2);
    put(1'b0, 8'd0);
    chk("t5_id3", 32'(o_frame_id), 32'd3);
    put(1'b0, 8'd0);
    chk("t5_id4", 32'(o_frame_id), 32'd4);
    chk("t5_sum4", 32'(o_sum), 32'd20);
    chk("t5_valid4", 32'(o_valid), 32'd1);
    put(1'b0, 8'd0);
    chk("t5_empty", 32'(o_valid), 32'd0);
    chk("t5_ovf_end", 32'(o_overflow), 32'd0);

    // 6: asynchronous reset mid-frame with a record pending
    do_reset();
    o_ready = 1'b0;
    feed_frame(8'd1);
    chk("t6_pending", 32'(o_valid), 32'd1);
    put(1'b1, 8'd50); put(1'b1, 8'd60);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(o_valid), 32'd0);
    chk("t6_async_sum", 32'(o_sum), 32'd0);
    chk("t6_async_max", 32'(o_max), 32'd0);
    #1;
    rst = 1'b0;
    o_ready = 1'b1;
    put(1'b1, 8'd1); put(1'b1, 8'd2); put(1'b1, 8'd3); put(1'b1, 8'd4);
    chk("t6_sum", 32'(o_sum), 32'd10);
    chk("t6_max", 32'(o_max), 32'd4);
    chk("t6_id", 32'(o_frame_id), 32'd0);
    chk("t6_valid", 32'(o_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
